apb_rw_scheduler: RTL
=====================

Name: apb_rw_scheduler

Overview:
- Shares one APB master port between a write-request channel and a read-request channel from the AXI4-Lite side of the bridge.
- Round-robin arbitration; one transfer in flight at a time.
- Sequences the APB SETUP/ACCESS phases and returns per-channel responses.
- Sits between the AXI-side request FIFOs and the APB bus.

Parameters:
- DATAWIDTH, 32, APB data width.
- ADDRWIDTH, 32, APB address width.
- STROBE_LEN, DATAWIDTH/8, byte-strobe width.
- PROT_LEN, 3, protection field width.
- TIMEOUT, 16, ACCESS cycles without pready before the transfer is forced to end with an error (minimum 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wr_req_valid  in  1  write request present.
- wr_req_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDRWIDTH  write address.
- wr_data  in  DATAWIDTH  write data.
- wr_strb  in  STROBE_LEN  write strobes.
- wr_prot  in  PROT_LEN  write protection.
- rd_req_valid  in  1  read request present.
- rd_req_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDRWIDTH  read address.
- rd_prot  in  PROT_LEN  read protection.
- wr_rsp_valid  out  1  write response available.
- wr_rsp_ready  in  1  write response consumed.
- wr_rsp_err  out  1  1 = SLVERR (maps to bresp 2'b10).
- rd_rsp_valid  out  1  read response available.
- rd_rsp_ready  in  1  read response consumed.
- rd_rsp_data  out  DATAWIDTH  read data.
- rd_rsp_err  out  1  1 = SLVERR (maps to rresp 2'b10).
- paddr  out  ADDRWIDTH  APB address.
- pwdata  out  DATAWIDTH  APB write data.
- pstrb  out  STROBE_LEN  APB strobes.
- pprot  out  PROT_LEN  APB protection.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- prdata  in  DATAWIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE.
  - last_grant = READ, so WRITE wins the first contention.
  - Timeout counter 0.
  - A reset mid-transfer abandons the transfer; no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and response outputs are registered.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the channel opposite last_grant.
  - Grant is signalled by a combinational wr_req_ready or rd_req_ready, high only in IDLE and only for the granted channel.
  - On grant: latch address/prot (and data/strb for writes); update last_grant; next state SETUP.
  - No requester valid: stay in IDLE.
- SETUP (1 cycle): psel=1, penable=0, pwrite = grant direction, paddr/pprot from latch. For writes, pwdata/pstrb from latch; for reads, pwdata=0 and pstrb=0. Next state ACCESS; counter cleared.
- ACCESS: psel=1, penable=1, all other APB outputs held stable.
  - pready=1: capture pslverr (and prdata for reads). Next cycle psel=penable=0, state RESP.
  - pready=0: increment the counter. When the counter reaches TIMEOUT-1 with pready still 0, end the transfer with err=1 and rd_rsp_data=0, then go to RESP.
- RESP:
  - Drive the matching rsp_valid with err (and data) held stable until its rsp_ready is sampled high.
  - Drop valid the following cycle; return to IDLE.
  - The other channel's rsp_valid stays 0.
- Timing: minimum 4 cycles per transfer from request acceptance to the next acceptance (IDLE → SETUP → ACCESS → RESP) with pready=1 in the first ACCESS cycle and rsp_ready held high.
- psel never deasserts between SETUP and the end of ACCESS.
- A request arriving during a transfer waits (ready=0) and must be held stable by the requester.
- Simultaneous new requests in the cycle a response completes are arbitrated in the next IDLE cycle.

Test Plan:
- Single write: addr=0x10, data=0xA5A5_0001, strb=0xF, pready high on the first ACCESS cycle → SETUP then ACCESS on consecutive cycles with paddr=0x10, pwrite=1; wr_rsp_valid the next cycle with err=0.
- Single read, pready delayed 3 cycles, prdata=0xDEAD_BEEF → penable high for 4 cycles; rd_rsp_data=0xDEAD_BEEF, err=0; pstrb=0 throughout.
- Both valid continuously for 4 transfers after reset → grant order W, R, W, R; wr_req_ready and rd_req_ready never high together.
- Read with pslverr=1 alongside pready → rd_rsp_err=1; then write with pslverr=0 → wr_rsp_err=0.
- pready held 0, TIMEOUT=16 → transfer ends after 16 ACCESS cycles with rd_rsp_err=1, rd_rsp_data=0; FSM returns to IDLE.
- rst pulled low during ACCESS → psel, penable and all rsp_valid go 0 immediately; after release the next contention is granted to WRITE.

Source files
------------

// File: rtl/apb_rw_scheduler_if.sv
// Request, response and APB signals of the read/write scheduler grouped as one bundle.
// master = the scheduler itself (drives APB), slave = the AXI-side FIFOs plus the APB target.
interface apb_rw_scheduler_if #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int STROBE_LEN = DATAWIDTH / 8,
  parameter int PROT_LEN   = 3
);
  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDRWIDTH-1:0]  wr_addr;
  logic [DATAWIDTH-1:0]  wr_data;
  logic [STROBE_LEN-1:0] wr_strb;
  logic [PROT_LEN-1:0]   wr_prot;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDRWIDTH-1:0]  rd_addr;
  logic [PROT_LEN-1:0]   rd_prot;
  logic                  wr_rsp_valid;
  logic                  wr_rsp_ready;
  logic                  wr_rsp_err;
  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [DATAWIDTH-1:0]  rd_rsp_data;
  logic                  rd_rsp_err;
  logic [ADDRWIDTH-1:0]  paddr;
  logic [DATAWIDTH-1:0]  pwdata;
  logic [STROBE_LEN-1:0] pstrb;
  logic [PROT_LEN-1:0]   pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATAWIDTH-1:0]  prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  wr_req_valid, wr_addr, wr_data, wr_strb, wr_prot,
    input  rd_req_valid, rd_addr, rd_prot,
    input  wr_rsp_ready, rd_rsp_ready,
    input  prdata, pready, pslverr,
    output wr_req_ready, rd_req_ready,
    output wr_rsp_valid, wr_rsp_err, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
    output paddr, pwdata, pstrb, pprot, psel, penable, pwrite
  );

  modport slave (
    output wr_req_valid, wr_addr, wr_data, wr_strb, wr_prot,
    output rd_req_valid, rd_addr, rd_prot,
    output wr_rsp_ready, rd_rsp_ready,
    output prdata, pready, pslverr,
    input  wr_req_ready, rd_req_ready,
    input  wr_rsp_valid, wr_rsp_err, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
    input  paddr, pwdata, pstrb, pprot, psel, penable, pwrite
  );
endinterface

// File: rtl/apb_rw_scheduler.sv
// Round-robin sharing of one APB master port between write and read request channels.
// One transfer in flight; APB and response outputs registered, request readies combinational in IDLE.
module apb_rw_scheduler #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int STROBE_LEN = DATAWIDTH / 8,
  parameter int PROT_LEN   = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  apb_rw_scheduler_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state;
  state_t                next_state;
  logic                  last_wr;
  logic                  is_wr;
  logic [CNT_W-1:0]      cnt;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  timed_out;
  logic                  access_end;
  logic                  rsp_taken;
  logic [ADDRWIDTH-1:0]  paddr_r;
  logic [DATAWIDTH-1:0]  pwdata_r;
  logic [STROBE_LEN-1:0] pstrb_r;
  logic [PROT_LEN-1:0]   pprot_r;
  logic                  psel_r;
  logic                  penable_r;
  logic                  wr_rsp_valid_r;
  logic                  wr_rsp_err_r;
  logic                  rd_rsp_valid_r;
  logic                  rd_rsp_err_r;
  logic [DATAWIDTH-1:0]  rd_rsp_data_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // last_wr = 0 means the previous grant went to the read channel
  always_comb begin
    grant_wr   = bus.wr_req_valid && (!bus.rd_req_valid || !last_wr);
    grant_rd   = bus.rd_req_valid && (!bus.wr_req_valid || last_wr);
    timed_out  = !bus.pready && (cnt == CNT_W'(TIMEOUT - 1));
    access_end = bus.pready || timed_out;
    rsp_taken  = is_wr ? bus.wr_rsp_ready : bus.rd_rsp_ready;
    next_state = state;
    case (state)
      IDLE:    if (grant_wr || grant_rd) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (access_end) next_state = RESP;
      RESP:    if (rsp_taken) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.wr_req_ready = (state == IDLE) && grant_wr;
  assign bus.rd_req_ready = (state == IDLE) && grant_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_wr        <= 1'b0;
      is_wr          <= 1'b0;
      cnt            <= '0;
      paddr_r        <= '0;
      pwdata_r       <= '0;
      pstrb_r        <= '0;
      pprot_r        <= '0;
      psel_r         <= 1'b0;
      penable_r      <= 1'b0;
      wr_rsp_valid_r <= 1'b0;
      wr_rsp_err_r   <= 1'b0;
      rd_rsp_valid_r <= 1'b0;
      rd_rsp_err_r   <= 1'b0;
      rd_rsp_data_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            is_wr     <= grant_wr;
            last_wr   <= grant_wr;
            paddr_r   <= grant_wr ? bus.wr_addr : bus.rd_addr;
            pprot_r   <= grant_wr ? bus.wr_prot : bus.rd_prot;
            pwdata_r  <= grant_wr ? bus.wr_data : '0;
            pstrb_r   <= grant_wr ? bus.wr_strb : '0;
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
          end
        end
        SETUP: begin
          penable_r <= 1'b1;
          cnt       <= '0;
        end
        ACCESS: begin
          if (access_end) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            if (is_wr) begin
              wr_rsp_valid_r <= 1'b1;
              wr_rsp_err_r   <= timed_out ? 1'b1 : bus.pslverr;
            end else begin
              rd_rsp_valid_r <= 1'b1;
              rd_rsp_err_r   <= timed_out ? 1'b1 : bus.pslverr;
              rd_rsp_data_r  <= timed_out ? '0 : bus.prdata;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_taken) begin
            wr_rsp_valid_r <= 1'b0;
            rd_rsp_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.paddr        = paddr_r;
  assign bus.pwdata       = pwdata_r;
  assign bus.pstrb        = pstrb_r;
  assign bus.pprot        = pprot_r;
  assign bus.psel         = psel_r;
  assign bus.penable      = penable_r;
  assign bus.pwrite       = is_wr;
  assign bus.wr_rsp_valid = wr_rsp_valid_r;
  assign bus.wr_rsp_err   = wr_rsp_err_r;
  assign bus.rd_rsp_valid = rd_rsp_valid_r;
  assign bus.rd_rsp_err   = rd_rsp_err_r;
  assign bus.rd_rsp_data  = rd_rsp_data_r;
endmodule
